// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the aux master, the dmem port and the arbiter.
interface dmem_arbiter_if;
  // CPU data port
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  // Auxiliary master (debug loader / DMA)
  logic        aux_req;
  logic        aux_we;
  logic [2:0]  aux_op;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic [31:0] aux_rdata;
  logic        aux_rvalid;
  // Shared dmem port
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [2:0]  mem_op;
  logic        mem_we;
  logic [31:0] mem_dataout;
  // Status
  logic [15:0] stall_count;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  aux_req, aux_we, aux_op, aux_addr, aux_wdata,
    output aux_gnt, aux_rdata, aux_rvalid,
    output mem_addr, mem_datain, mem_op, mem_we,
    input  mem_dataout,
    output stall_count
  );

  // Environment side (masters and memory)
  modport master (
    output cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output aux_req, aux_we, aux_op, aux_addr, aux_wdata,
    input  aux_gnt, aux_rdata, aux_rvalid,
    input  mem_addr, mem_datain, mem_op, mem_we,
    output mem_dataout,
    input  stall_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master dmem arbiter: CPU has priority, aux is guaranteed a slot after WAIT_LIMIT
// consecutive denied cycles. Read data is routed back by tracking who issued the last read.
module dmem_arbiter #(
  parameter int unsigned WAIT_LIMIT = 4  // legal 1..255
) (
  input logic            clock,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] Limit = WAIT_LIMIT[7:0];

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnAux  = 2'd2
  } owner_e;

  logic [7:0]  wait_cnt_q, wait_cnt_d;
  owner_e      rsp_owner_q, rsp_owner_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic grant_aux, grant_cpu;

  // Grant decision and dmem port mux
  always_comb begin
    grant_aux = bus.aux_req & (~bus.cpu_req | (wait_cnt_q >= Limit));
    grant_cpu = bus.cpu_req & ~grant_aux;

    bus.aux_gnt    = grant_aux;
    bus.cpu_stall  = bus.cpu_req & grant_aux;

    bus.mem_addr   = 32'h0;
    bus.mem_datain = 32'h0;
    bus.mem_op     = 3'h0;
    bus.mem_we     = 1'b0;
    if (grant_aux) begin
      bus.mem_addr   = bus.aux_addr;
      bus.mem_datain = bus.aux_wdata;
      bus.mem_op     = bus.aux_op;
      bus.mem_we     = bus.aux_we;
    end else if (grant_cpu) begin
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_datain = bus.cpu_wdata;
      bus.mem_op     = bus.cpu_op;
      bus.mem_we     = bus.cpu_we;
    end
  end

  // Read data is shared; only the valid flags depend on who issued the read
  always_comb begin
    bus.cpu_rdata   = bus.mem_dataout;
    bus.aux_rdata   = bus.mem_dataout;
    bus.cpu_rvalid  = (rsp_owner_q == OwnCpu);
    bus.aux_rvalid  = (rsp_owner_q == OwnAux);
    bus.stall_count = stall_count_q;
  end

  // Next state: aux wait counter, response owner, stall statistics
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    rsp_owner_d   = OwnNone;
    stall_count_d = stall_count_q;

    if (grant_aux || !bus.aux_req) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < Limit) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if (grant_cpu && !bus.cpu_we) begin
      rsp_owner_d = OwnCpu;
    end else if (grant_aux && !bus.aux_we) begin
      rsp_owner_d = OwnAux;
    end

    if (bus.cpu_stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q    <= 8'd0;
      rsp_owner_q   <= OwnNone;
      stall_count_q <= 16'd0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_owner_q   <= rsp_owner_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic checked
// against a cycle-level behavioural model with its own copy of memory contents.
module tb_dmem_arbiter;

  localparam int unsigned WaitLimit = 4;

  logic clock;
  logic reset;

  dmem_arbiter_if ifc ();

  dmem_arbiter #(
    .WAIT_LIMIT(WaitLimit)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment memory: 8 words at 0x8000..0x801C, synchronous read
  bit [31:0] env_mem [8];
  always @(posedge clock) begin
    ifc.mem_dataout <= env_mem[ifc.mem_addr[4:2]];
    if (ifc.mem_we) env_mem[ifc.mem_addr[4:2]] <= ifc.mem_datain;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  int        m_wait  = 0;
  int        m_stall = 0;
  bit        m_cpu_rv = 0;
  bit        m_aux_rv = 0;
  bit [31:0] m_rdata = 0;
  bit [31:0] m_mem [8];
  bit        m_known = 0;

  // One clock cycle: drive inputs after the falling edge, check combinational and registered
  // outputs against the model, then advance the model to what the next rising edge produces.
  task automatic cycle(input bit rst,
                       input bit creq, input bit cwe, input bit [2:0] cop,
                       input bit [31:0] caddr, input bit [31:0] cwdata,
                       input bit areq, input bit awe, input bit [2:0] aop,
                       input bit [31:0] aaddr, input bit [31:0] awdata);
    bit ea, ec, ewe;
    bit [31:0] eaddr, edata;
    bit [2:0] eop;
    @(negedge clock);
    reset         = rst;
    ifc.cpu_req   = creq;  ifc.cpu_we = cwe;  ifc.cpu_op = cop;
    ifc.cpu_addr  = caddr; ifc.cpu_wdata = cwdata;
    ifc.aux_req   = areq;  ifc.aux_we = awe;  ifc.aux_op = aop;
    ifc.aux_addr  = aaddr; ifc.aux_wdata = awdata;
    #1;
    ea = areq && (!creq || m_wait >= int'(WaitLimit));
    ec = creq && !ea;
    {ewe, eaddr, edata, eop} = '0;
    if (ea)      {ewe, eaddr, edata, eop} = {awe, aaddr, awdata, aop};
    else if (ec) {ewe, eaddr, edata, eop} = {cwe, caddr, cwdata, cop};
    if (m_known) begin
      check("aux_gnt",     ifc.aux_gnt,    32'(ea));
      check("cpu_stall",   ifc.cpu_stall,  32'(creq && ea));
      check("mem_we",      ifc.mem_we,     32'(ewe));
      check("mem_addr",    ifc.mem_addr,   eaddr);
      check("mem_datain",  ifc.mem_datain, edata);
      check("mem_op",      ifc.mem_op,     32'(eop));
      check("cpu_rvalid",  ifc.cpu_rvalid, 32'(m_cpu_rv));
      check("aux_rvalid",  ifc.aux_rvalid, 32'(m_aux_rv));
      if (m_cpu_rv) check("cpu_rdata", ifc.cpu_rdata, m_rdata);
      if (m_aux_rv) check("aux_rdata", ifc.aux_rdata, m_rdata);
      check("stall_count", ifc.stall_count, 32'(m_stall));
    end
    // Advance model across the coming rising edge
    m_cpu_rv = ec && !cwe;
    m_aux_rv = ea && !awe;
    if ((ea || ec) && !ewe) m_rdata = m_mem[eaddr[4:2]];
    if ((ea || ec) && ewe)  m_mem[eaddr[4:2]] = edata;
    if (ea || !areq) m_wait = 0;
    else if (m_wait < int'(WaitLimit)) m_wait++;
    if (creq && ea && m_stall < 65535) m_stall++;
    if (rst) begin
      m_wait = 0; m_stall = 0; m_cpu_rv = 0; m_aux_rv = 0; m_known = 1;
    end
  endtask

  task automatic idle(input bit rst);
    cycle(rst, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic both_read(input bit rst);
    cycle(rst, 1, 0, 3'd2, 32'h8004, 32'h0, 1, 0, 3'd2, 32'h8008, 32'h0);
  endtask

  initial begin
    bit [11:0] gseq;
    reset = 1'b0;
    ifc.cpu_req = 0; ifc.cpu_we = 0; ifc.cpu_op = 0; ifc.cpu_addr = 0; ifc.cpu_wdata = 0;
    ifc.aux_req = 0; ifc.aux_we = 0; ifc.aux_op = 0; ifc.aux_addr = 0; ifc.aux_wdata = 0;

    // Reset state
    idle(1);
    idle(0);
    check("rst_cpu_rvalid", ifc.cpu_rvalid, 0);
    check("rst_aux_rvalid", ifc.aux_rvalid, 0);
    check("rst_stall_cnt",  ifc.stall_count, 0);

    // CPU only: write then read back
    cycle(0, 1, 1, 3'd2, 32'h8014, 32'd1234, 0, 0, 3'd0, 32'h0, 32'h0);
    check("cpu_wr_mem_we", ifc.mem_we, 1);
    check("cpu_wr_stall",  ifc.cpu_stall, 0);
    cycle(0, 1, 0, 3'd2, 32'h8014, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    check("cpu_rd_stall",  ifc.cpu_stall, 0);
    idle(0);
    check("cpu_rd_rvalid", ifc.cpu_rvalid, 1);
    check("cpu_rd_rdata",  ifc.cpu_rdata, 32'd1234);

    // Aux only: preload 0xff, then read it
    cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, 1, 3'd2, 32'h8018, 32'hff);
    cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 3'd2, 32'h8018, 32'h0);
    check("aux_rd_gnt", ifc.aux_gnt, 1);
    idle(0);
    check("aux_rd_rvalid", ifc.aux_rvalid, 1);
    check("aux_rd_rdata",  ifc.aux_rdata, 32'hff);
    check("aux_rd_cpu_rv", ifc.cpu_rvalid, 0);

    // Contention for 12 cycles: aux wins in cycles 4 and 9
    idle(1);
    for (int i = 0; i < 12; i++) begin
      both_read(0);
      gseq[i] = ifc.aux_gnt;
    end
    check("contend_seq", 32'(gseq), 32'h210);
    idle(0);
    check("contend_stall_cnt", ifc.stall_count, 2);

    // Response routing: CPU read at n, aux read at n+1
    cycle(0, 1, 0, 3'd2, 32'h8014, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    check("route_n_cpu_rv", ifc.cpu_rvalid, 0);
    cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 3'd2, 32'h8018, 32'h0);
    check("route_n1_cpu_rv", ifc.cpu_rvalid, 1);
    check("route_n1_aux_rv", ifc.aux_rvalid, 0);
    idle(0);
    check("route_n2_cpu_rv", ifc.cpu_rvalid, 0);
    check("route_n2_aux_rv", ifc.aux_rvalid, 1);
    check("route_n2_rdata",  ifc.aux_rdata, 32'hff);

    // Reset arriving on the edge that ends a granted CPU read
    both_read(0); both_read(0);
    cycle(1, 1, 0, 3'd2, 32'h8014, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    idle(0);
    check("rstmid_cpu_rv",    ifc.cpu_rvalid, 0);
    check("rstmid_stall_cnt", ifc.stall_count, 0);
    // Counter cleared: first contended cycle goes to CPU
    both_read(0);
    check("rstmid_wait_cnt", ifc.aux_gnt, 0);

    // Aux withdraw restarts its wait
    idle(1);
    for (int i = 0; i < 3; i++) both_read(0);
    cycle(0, 1, 0, 3'd2, 32'h8004, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      both_read(0);
      check($sformatf("withdraw_gnt%0d", i), ifc.aux_gnt, (i == 4) ? 1 : 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 3'($urandom),
            32'h8000 + 32'($urandom_range(0, 7) * 4), $urandom,
            ($urandom_range(0, 2) != 0), $urandom_range(0, 1), 3'($urandom),
            32'h8000 + 32'($urandom_range(0, 7) * 4), $urandom);
    end
    idle(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
